exception_unit: RTL

- Sequencer that takes the three exception conditions (invalid opcode, overflow, divide-by-zero) from the datapath and control unit.
- Saves the faulting PC to EPC and records the cause.
- Drives the 3-bit vector-select code into the exception-address mux, which maps it to vector bytes 253/254/255.
- Reads the vector byte from memory, then loads the zero-extended handler address into PC while the main control FSM is stalled.

---
 rtl/cpu_defs.sv | 45 ++++
 rtl/exception_unit_wait_counter.sv | 35 +++
 rtl/exception_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Shared encodings for the exception sequencer and the
//                exception-address mux: states, causes, mux codes, vectors.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_OPCODE   = 2'b00,
        CAUSE_OVERFLOW = 2'b01,
        CAUSE_DIV0     = 2'b10
    } cause_t;

    // Must match the select decoding inside the exception-address mux.
    localparam logic [2:0] c_ctrl_opcode   = 3'b000;
    localparam logic [2:0] c_ctrl_overflow = 3'b001;
    localparam logic [2:0] c_ctrl_div0     = 3'b010;

    localparam logic [7:0] c_vec_opcode   = 8'd253;
    localparam logic [7:0] c_vec_overflow = 8'd254;
    localparam logic [7:0] c_vec_div0     = 8'd255;

    function automatic logic [2:0] cause_to_ctrl(input cause_t cause);
        logic [2:0] ctrl;
        case (cause)
            CAUSE_OVERFLOW: ctrl = c_ctrl_overflow;
            CAUSE_DIV0:     ctrl = c_ctrl_div0;
            default:        ctrl = c_ctrl_opcode;
        endcase
        return ctrl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/exception_unit_wait_counter.sv
// ============================================================================
//  Module      : wait_counter
//  Description : Loadable down-counter with enable and zero flag; stops at 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/exception_unit.sv
// ============================================================================
//  Module      : exception_unit
//  Description : Captures EPC/cause, fetches the vector byte and loads the
//                handler address into PC while the control FSM is stalled.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module exception_unit
    import cpu_defs::*;
#(
    parameter int MEM_LAT   = 1,
    parameter int PC_OFFSET = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        opcode_invalid,
    input  logic        overflow,
    input  logic        div_zero,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [2:0]  excpt_ctrl,
    output logic        mem_read,
    output logic        excpt_addr_sel,
    output logic        busy,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        pc_load,
    output logic [31:0] handler_pc
);

    localparam int                 c_cnt_w    = $clog2(MEM_LAT) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(MEM_LAT - 1);

    state_t      r_state;
    state_t      w_next_state;
    cause_t      r_cause;
    cause_t      w_cause_sel;
    logic [31:0] r_epc;
    logic [31:0] r_handler;
    logic        w_any_exc;
    logic        w_cnt_zero;
    logic        w_cnt_load;
    logic        w_cnt_en;
    logic [23:0] w_unused_mem_hi;

    // Only the vector byte is meaningful; the upper read data is discarded.
    assign w_unused_mem_hi = mem_data_in[31:8];

    assign w_any_exc = opcode_invalid | overflow | div_zero;

    always_comb begin
        w_cause_sel = CAUSE_OPCODE;
        if (div_zero) begin
            w_cause_sel = CAUSE_DIV0;
        end else if (overflow) begin
            w_cause_sel = CAUSE_OVERFLOW;
        end
    end

    assign w_cnt_load = (r_state == ST_FETCH);
    assign w_cnt_en   = (r_state == ST_WAIT);

    wait_counter #(
        .WIDTH (c_cnt_w)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_cnt_load),
        .i_enable   (w_cnt_en),
        .i_load_val (c_cnt_init),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_exc) w_next_state = ST_FETCH;
            ST_FETCH: w_next_state = ST_WAIT;
            ST_WAIT:  if (w_cnt_zero) w_next_state = ST_LOAD;
            ST_LOAD:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cause   <= CAUSE_OPCODE;
            r_epc     <= '0;
            r_handler <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && w_any_exc) begin
                r_cause <= w_cause_sel;
                r_epc   <= pc_in - 32'(PC_OFFSET);
            end
            if ((r_state == ST_WAIT) && w_cnt_zero) begin
                r_handler <= {24'b0, mem_data_in[7:0]};
            end
        end
    end

    // Mux select stays valid through WAIT so the read address is stable.
    always_comb begin
        excpt_ctrl     = c_ctrl_opcode;
        mem_read       = 1'b0;
        excpt_addr_sel = 1'b0;
        pc_load        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                excpt_ctrl     = cause_to_ctrl(r_cause);
                mem_read       = 1'b1;
                excpt_addr_sel = 1'b1;
            end
            ST_WAIT: begin
                excpt_ctrl     = cause_to_ctrl(r_cause);
                excpt_addr_sel = 1'b1;
            end
            ST_LOAD: pc_load = 1'b1;
            default: ;
        endcase
    end

    assign busy       = (r_state != ST_IDLE);
    assign epc        = r_epc;
    assign cause      = r_cause;
    assign handler_pc = r_handler;

endmodule

`default_nettype wire
